// File: rtl/uart_pkg.sv
// Shared state encoding and line-level constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Loadable shift-right register with saturating bit counter; done_o flags the last data bit.
// Load takes priority over shift/step; no backpressure, controlled entirely by the frame FSM.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic                 step_i,
  input  logic [BUS_WIDTH-1:0] data_i,
  output logic                 bit_o,
  output logic                 done_o
);

  localparam int CNT_W = $clog2(BUS_WIDTH);

  logic [BUS_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign bit_o  = shreg_q[0];
  assign done_o = (cnt_q == CNT_W'(BUS_WIDTH - 1));

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
    end else begin
      if (shift_i) shreg_d = shreg_q >> 1;
      // Saturate at the last bit index so the counter never wraps.
      if (step_i && !done_o) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART TX framer: start, LSB-first data, optional parity, stop; one bit per CLK, TX_OUT 1 cycle after accept.
// Requests only taken in IDLE (and STOP with UART_TX_BACK2BACK_EN defined); BUSY is the backpressure.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] P_DATA,
  input  logic                 DATA_VALID,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  output logic                 TX_OUT,
  output logic                 BUSY
);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_en_d;
  logic      par_q, par_d;
  logic      load, shift, step, accept;
  logic      ser_bit, ser_done;

  uart_tx_serializer #(.BUS_WIDTH(BUS_WIDTH)) u_ser (
    .clk_i  (CLK),
    .rst_ni (RST),
    .load_i (load),
    .shift_i(shift),
    .step_i (step),
    .data_i (P_DATA),
    .bit_o  (ser_bit),
    .done_o (ser_done)
  );

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

  always_comb begin
    state_d  = state_q;
    tx_d     = LINE_IDLE;
    busy_d   = 1'b0;
    par_en_d = par_en_q;
    par_d    = par_q;
    load     = 1'b0;
    shift    = 1'b0;
    step     = 1'b0;
    accept   = 1'b0;

    case (state_q)
      IDLE:   accept = DATA_VALID;
      // Bit 0 goes onto the line as START ends; counter already sits at 0 from load.
      START: begin
        state_d = DATA;
        tx_d    = ser_bit;
        shift   = 1'b1;
        busy_d  = 1'b1;
      end
      DATA: begin
        busy_d = 1'b1;
        if (!ser_done) begin
          tx_d  = ser_bit;
          shift = 1'b1;
          step  = 1'b1;
        end else if (par_en_q) begin
          state_d = PARITY;
          tx_d    = par_q;
        end else begin
          state_d = STOP;
          tx_d    = STOP_BIT;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_BIT;
        busy_d  = 1'b1;
      end
      STOP: begin
        state_d = IDLE;
`ifdef UART_TX_BACK2BACK_EN
        accept  = DATA_VALID;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      load     = 1'b1;
      par_en_d = PAR_EN;
      par_d    = (^P_DATA) ^ PAR_TYP;
      state_d  = START;
      tx_d     = START_BIT;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      tx_q     <= LINE_IDLE;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomized scoreboard bench for uart_tx_frame: frame model predicts accepts and bit sequences.
module tb_uart_tx_frame;

  localparam int BW = 8;
`ifdef UART_TX_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [BW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_OUT;
  logic          BUSY;

  uart_tx_frame #(.BUS_WIDTH(BW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   free_cyc = 0;
  int   last_start = 0;
  int   abort_cyc = -1;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
    end
  endtask

  // Reference frame: start bit, data LSB-first, parity from a ones count, stop bit.
  task automatic model_accept(input logic [BW-1:0] d, input logic pen, input logic typ,
                              input int start);
    exp_t e;
    int   ones;
    int   n;
    ones   = 0;
    e.bits = '0;
    e.bits[0] = 1'b0;
    for (int i = 0; i < BW; i++) begin
      e.bits[i+1] = d[i];
      ones += int'(d[i]);
    end
    n = BW + 1;
    if (pen) begin
      e.bits[n] = ((ones % 2) != 0) ^ typ;
      n++;
    end
    e.bits[n]   = 1'b1;
    e.len       = n + 1;
    e.start_cyc = start;
    sb.push_back(e);
    free_cyc   = start + e.len;
    last_start = start;
  endtask

  task automatic cyc_drive(input logic dv, input logic [BW-1:0] d, input logic pen,
                           input logic typ);
    @(negedge CLK);
    RST        = 1'b1;
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = typ;
    if (dv && (cyc >= free_cyc || (B2B && cyc == free_cyc - 1)))
      model_accept(d, pen, typ, cyc + 1);
  endtask

  task automatic rst_pulse();
    @(negedge CLK);
    RST        = 1'b0;
    DATA_VALID = 1'b0;
    abort_cyc  = cyc + 1;
    free_cyc   = cyc + 1;
  endtask

  task automatic drive_until_idle();
    while (cyc < free_cyc + 1)
      cyc_drive(1'b0, BW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic send(input logic [BW-1:0] d, input logic pen, input logic typ);
    cyc_drive(1'b1, d, pen, typ);
    drive_until_idle();
  endtask

  // Monitor: every cycle is either a predicted frame bit or the idle line.
  initial begin
    exp_t cur;
    bit   in_frame;
    int   idx;
    in_frame = 1'b0;
    idx      = 0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (in_frame && cyc == abort_cyc) in_frame = 1'b0;
        if (!in_frame && sb.size() > 0 && sb[0].start_cyc == cyc) begin
          cur      = sb.pop_front();
          in_frame = 1'b1;
          idx      = 0;
        end
        if (in_frame) begin
          check("tx_bit", TX_OUT, cur.bits[idx]);
          check("busy_in_frame", BUSY, 1'b1);
          idx++;
          if (idx == cur.len) in_frame = 1'b0;
        end else begin
          check("tx_idle", TX_OUT, 1'b1);
          check("busy_idle", BUSY, 1'b0);
        end
      end
    end
  end

  initial begin
    int st;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", BUSY, 1'b0);
    free_cyc = cyc + 1;
    mon_en   = 1'b1;

    send(8'hA5, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b1);
    send(8'h00, 1'b1, 1'b1);
    send(8'h01, 1'b0, 1'b0);

    // Requests mid-frame and in the stop cycle with changing inputs.
    cyc_drive(1'b1, 8'h5A, 1'b1, 1'b0);
    st = last_start;
    for (int k = 0; k < 14; k++)
      cyc_drive((st + k == st + 3) || (st + k == st + 10), 8'hFF, 1'b1, 1'($urandom));
    drive_until_idle();

    // Reset while data bit 3 is on the line.
    cyc_drive(1'b1, 8'h96, 1'b1, 1'b0);
    st = last_start;
    repeat (4) cyc_drive(1'b0, 8'hFF, 1'b0, 1'b1);
    rst_pulse();
    drive_until_idle();
    send(BW'($urandom), 1'b1, 1'($urandom));

    repeat (60) cyc_drive(1'b1, 8'h3C, 1'b1, 1'b0);
    drive_until_idle();

    repeat (400)
      cyc_drive($urandom_range(0, 3) == 0, BW'($urandom), 1'($urandom), 1'($urandom));
    drive_until_idle();
    repeat (3) cyc_drive(1'b0, 8'h00, 1'b0, 1'b0);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit path, the counterpart of the receive-side parity checker. It accepts one parallel word per handshake and serializes it LSB-first on TX_OUT as one frame: start bit, data bits, optional parity bit, stop bit. One CLK cycle equals one bit period; the baud-rate prescaler sits upstream and drives CLK. The block sits between the UART system-control logic and the TX pad.

Parameters:
BUS_WIDTH, 8, number of data bits per frame (legal range 5..9)

Ports:
CLK  input  1  bit-rate clock; all logic on rising edge
RST  input  1  reset, synchronous, active-low
P_DATA  input  BUS_WIDTH  parallel word to transmit
DATA_VALID  input  1  request; sampled only when accepting
PAR_EN  input  1  1 = frame includes parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line; idle level 1
BUSY  output  1  1 while a frame is in progress

Behaviour:
- Reset: any rising CLK edge with RST=0 gives state IDLE, TX_OUT=1, BUSY=0, and bit counter, shift register and parity register cleared. This applies in every state, including mid-frame; the frame is abandoned with no stop bit.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. On an edge with DATA_VALID=1:
  - latch P_DATA, PAR_EN and PAR_TYP;
  - compute parity bit = (^P_DATA) XOR PAR_TYP;
  - go to START.
- Latency: with acceptance at edge k, TX_OUT=0 and BUSY=1 during cycle k+1.
- START: one cycle, TX_OUT=0, then go to DATA.
- DATA: BUS_WIDTH cycles. TX_OUT = current LSB of the shift register, which shifts right each cycle. The bit counter runs 0..BUS_WIDTH-1. After the last bit, go to PARITY if the latched PAR_EN=1, otherwise go to STOP.
- PARITY: one cycle, TX_OUT = latched parity bit, then go to STOP.
- STOP: one cycle, TX_OUT=1, BUSY=1, then go to IDLE (BUSY=0 the following cycle).
- Frame length in cycles = BUS_WIDTH + 2 + PAR_EN.
- DATA_VALID is ignored in every state except IDLE (and STOP when the optional feature is enabled). Changes to P_DATA, PAR_EN or PAR_TYP while BUSY=1 do not affect the current frame.
- Bit counter width = clog2(BUS_WIDTH). The counter must not wrap past BUS_WIDTH-1.

Optional Feature:
- UART_TX_BACK2BACK_EN
- Defined: in STOP, an edge with DATA_VALID=1 latches the new word and goes directly to START. BUSY stays 1 and there is no idle bit between frames, so the throughput is one frame per BUS_WIDTH+2+PAR_EN cycles.
- Undefined: STOP always returns to IDLE, giving at least one idle-high cycle between frames, and DATA_VALID during STOP is ignored.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants PAR_EVEN=1'b0, PAR_ODD=1'b1, LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- One natural sub-module, uart_tx_serializer: load, shift-right register plus bit counter with a done flag, parameterized by BUS_WIDTH.
- The FSM, parity register and output register stay in uart_tx_frame.

Test Plan:
- Even parity: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, one-cycle DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop); BUSY high for exactly 11 cycles starting 1 cycle after acceptance.
- Odd parity: same word with PAR_TYP=1 -> identical frame except the parity bit is 1. Also P_DATA=8'h00, PAR_TYP=1 -> parity bit 1.
- No parity: P_DATA=8'h01, PAR_EN=0 -> 0,1,0,0,0,0,0,0,0,1; BUSY high for 10 cycles; the PARITY state is never entered.
- Ignored request and held data: pulse DATA_VALID with P_DATA=8'hFF mid-frame and change P_DATA/PAR_TYP -> current frame unchanged, no second frame. Without the macro, DATA_VALID in STOP is also ignored; with it, the next start bit immediately follows the stop bit.
- Reset mid-frame: RST=0 for one edge during data bit 3 -> the next cycle TX_OUT=1, BUSY=0, state IDLE. A new DATA_VALID afterwards yields a complete, correct frame.
- Continuous DATA_VALID=1 with P_DATA=8'h3C, PAR_EN=1, PAR_TYP=0: frames repeat, each checked bitwise (parity 0). Without the macro there is exactly one idle cycle between frames; with it there are none.
